vc_dispatch_sel: RTL and testbench

Selects which virtual channel of an input port dispatches a flit toward the output port granted by the switch allocator. Arbitration among matching VCs is configurable as fixed-priority or round-robin, and skips VCs with no downstream credit. Wormhole packet locking holds the chosen VC from head flit to tail flit. Sits between the per-port VC buffers and the crossbar, one instance per input port.

---
 rtl/vr_pkg.sv | 19 +
 rtl/rr_mask_arbiter.sv | 45 ++++
 rtl/vc_dispatch_sel.sv | 139 +++++++++++++
 tb/tb_vc_dispatch_sel.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vr_pkg
// Description : Shared constants and helpers for the VC dispatch selector.
// Revision    : 1.0  initial release
// ============================================================================
package vr_pkg;

    // Arbitration mode encodings for the ARB_MODE parameter
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Wrapping increment: (ptr + 1) mod n, valid for any n >= 1
    function automatic int mod_inc(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mask_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mask_arbiter
// Description : Combinational round-robin arbiter. Searches upward from ptr
//               by masking off requests below ptr; falls back to the full
//               request vector (the wrap-around case) when the mask is empty.
// Revision    : 1.0  initial release
// ============================================================================
module rr_mask_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int IDX_BITS = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] requests,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_BITS-1:0] index,
    output logic                any
);

    logic [NUM_REQS-1:0] masked;
    logic [NUM_REQS-1:0] search;
    logic                found;

    // Lowest-index request at or above ptr, else lowest-index request overall
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            masked[i] = requests[i] & (i >= int'(ptr));
        end
        search = (|masked) ? masked : requests;
        grant  = '0;
        index  = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (search[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                index    = IDX_BITS'(i);
            end
        end
        any = |requests;
    end

endmodule
`default_nettype wire

// File: rtl/vc_dispatch_sel.sv
`default_nettype none
// ============================================================================
// Module      : vc_dispatch_sel
// Description : Picks the virtual channel of one input port that sends a flit
//               to the output port granted by the switch allocator. Holds a
//               wormhole lock from head to tail flit; skips VCs with no
//               downstream credit. Grant is combinational (0-cycle latency).
// Revision    : 1.0  initial release
// ============================================================================
module vc_dispatch_sel
    import vr_pkg::*;
#(
    parameter int NUM_VC    = 4,
    parameter int NUM_PORTS = 4,
    parameter int ARB_MODE  = 1,
    parameter int VC_BITS   = $clog2(NUM_VC)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_VC-1:0]                 vc_valid,
    input  logic [NUM_VC-1:0][NUM_PORTS-1:0]  vc_direction,
    input  logic [NUM_VC-1:0]                 vc_tail,
    input  logic [NUM_VC-1:0]                 vc_credit_ok,
    input  logic [NUM_PORTS-1:0]              sel_direction,
    input  logic                              sel_valid,
    output logic [VC_BITS-1:0]                vc_index,
    output logic                              grant_valid,
    output logic                              dispatch,
    output logic                              locked
);

    logic               locked_q, locked_d;
    logic [VC_BITS-1:0] lock_vc_q, lock_vc_d;
    logic [VC_BITS-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_VC-1:0]  eligible;
    logic [NUM_VC-1:0]  arb_grant;
    logic [VC_BITS-1:0] arb_idx;
    logic               arb_any;
    logic [NUM_VC-1:0]  lock_oh;
    logic [NUM_VC-1:0]  sel_oh;
    logic               sel_is_tail;

    // A VC competes only if it has a flit, a credit, and heads our way
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            eligible[i] = vc_valid[i] & vc_credit_ok[i] &
                          (vc_direction[i] == sel_direction);
        end
    end

    generate
        if (ARB_MODE == ARB_RR) begin : g_rr
            rr_mask_arbiter #(
                .NUM_REQS (NUM_VC),
                .IDX_BITS (VC_BITS)
            ) u_arb (
                .requests (eligible),
                .ptr      (rr_ptr_q),
                .grant    (arb_grant),
                .index    (arb_idx),
                .any      (arb_any)
            );
        end else begin : g_fixed
            // Highest eligible index wins: later hits overwrite earlier ones
            always_comb begin
                arb_grant = '0;
                arb_idx   = '0;
                arb_any   = 1'b0;
                for (int i = 0; i < NUM_VC; i++) begin
                    if (eligible[i]) begin
                        arb_grant    = '0;
                        arb_grant[i] = 1'b1;
                        arb_idx      = VC_BITS'(i);
                        arb_any      = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign lock_oh = NUM_VC'(1) << lock_vc_q;

    // Grant outputs: the locked VC alone while a packet is in flight
    always_comb begin
        vc_index    = '0;
        grant_valid = 1'b0;
        sel_oh      = '0;
        if (reset) begin
            if (locked_q) begin
                vc_index    = lock_vc_q;
                grant_valid = |(lock_oh & eligible);
                sel_oh      = lock_oh;
            end else begin
                vc_index    = arb_idx;
                grant_valid = arb_any;
                sel_oh      = arb_grant;
            end
        end
    end

    assign dispatch    = grant_valid & sel_valid;
    assign sel_is_tail = |(sel_oh & vc_tail);
    assign locked      = locked_q;

    // Lock and pointer next state; only a dispatch changes anything
    always_comb begin
        locked_d  = locked_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        if (dispatch) begin
            if (sel_is_tail) begin
                locked_d = 1'b0;
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr_d = VC_BITS'(mod_inc(int'(vc_index), NUM_VC));
                end
            end else if (!locked_q) begin
                locked_d  = 1'b1;
                lock_vc_d = vc_index;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            locked_q  <= 1'b0;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            locked_q  <= locked_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vc_dispatch_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_dispatch_sel
// Description : Self-checking bench for vc_dispatch_sel. One round-robin and
//               one fixed-priority instance share the stimulus; each vector
//               names which instance it checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vc_dispatch_sel;

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic [3:0] dir;
        logic [3:0] tail;
        logic [3:0] credit;
        logic [3:0] sel_dir;
        logic       sel_v;
        logic       mode;
        logic       chk_lk;
        logic [1:0] e_idx;
        logic       e_gv;
        logic       e_disp;
        logic       e_lk;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      vc_valid;
    logic [3:0][3:0] vc_direction;
    logic [3:0]      vc_tail;
    logic [3:0]      vc_credit_ok;
    logic [3:0]      sel_direction;
    logic            sel_valid;

    logic [1:0] idx_rr, idx_fp;
    logic       gv_rr, gv_fp, disp_rr, disp_fp, lk_rr, lk_fp;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    vc_dispatch_sel #(.NUM_VC(4), .NUM_PORTS(4), .ARB_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .vc_valid(vc_valid), .vc_direction(vc_direction),
        .vc_tail(vc_tail), .vc_credit_ok(vc_credit_ok), .sel_direction(sel_direction),
        .sel_valid(sel_valid), .vc_index(idx_rr), .grant_valid(gv_rr),
        .dispatch(disp_rr), .locked(lk_rr));

    vc_dispatch_sel #(.NUM_VC(4), .NUM_PORTS(4), .ARB_MODE(0)) u_fp (
        .clk(clk), .reset(reset), .vc_valid(vc_valid), .vc_direction(vc_direction),
        .vc_tail(vc_tail), .vc_credit_ok(vc_credit_ok), .sel_direction(sel_direction),
        .sel_valid(sel_valid), .vc_index(idx_fp), .grant_valid(gv_fp),
        .dispatch(disp_fp), .locked(lk_fp));

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] d,
                                input logic [3:0] t, input logic [3:0] c, input logic [3:0] sd,
                                input logic sv, input logic m, input logic cl,
                                input logic [1:0] ei, input logic eg, input logic ed,
                                input logic el);
        vec_t x;
        x.rst_n = r;  x.valid = v;  x.dir = d;  x.tail = t;  x.credit = c;
        x.sel_dir = sd; x.sel_v = sv; x.mode = m; x.chk_lk = cl;
        x.e_idx = ei; x.e_gv = eg; x.e_disp = ed; x.e_lk = el;
        return x;
    endfunction

    task automatic cmp1(input int id, input string what, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %0d, expected %0d", id, what, act, req);
        end
    endtask

    // Pop the oldest expectation and compare it with the instance it names
    task automatic check(input int id);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL vec%0d scoreboard: got empty queue, expected an entry", id);
            return;
        end
        e = exp_q.pop_front();
        cmp1(id, "vc_index",    int'(e.mode ? idx_rr  : idx_fp),  int'(e.e_idx));
        cmp1(id, "grant_valid", int'(e.mode ? gv_rr   : gv_fp),   int'(e.e_gv));
        cmp1(id, "dispatch",    int'(e.mode ? disp_rr : disp_fp), int'(e.e_disp));
        if (e.chk_lk)
            cmp1(id, "locked",  int'(e.mode ? lk_rr   : lk_fp),   int'(e.e_lk));
    endtask

    // Drive one cycle of stimulus, sample mid-cycle, then cross the clock edge
    task automatic apply(input vec_t v, input int id);
        reset         = v.rst_n;
        vc_valid      = v.valid;
        for (int k = 0; k < 4; k++) vc_direction[k] = v.dir;
        vc_tail       = v.tail;
        vc_credit_ok  = v.credit;
        sel_direction = v.sel_dir;
        sel_valid     = v.sel_v;
        exp_q.push_back(v);
        #2;
        check(id);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        localparam logic [3:0] D = 4'b0010;
        localparam logic [3:0] F = 4'b1111;
        localparam logic [3:0] Z = 4'b0000;

        // Reset held two cycles with everything eligible
        tbl.push_back(mk(0, F, D, F, F, D, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, F, D, F, F, D, 1, 0, 0, 0, 0, 0, 0));
        // Round-robin over single-flit packets: 0,1,2,3,0
        tbl.push_back(mk(1, F, D, F, F, D, 1, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, F, D, F, F, D, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, F, D, F, F, D, 1, 1, 1, 2, 1, 1, 0));
        tbl.push_back(mk(1, F, D, F, F, D, 1, 1, 1, 3, 1, 1, 0));
        tbl.push_back(mk(1, F, D, F, F, D, 1, 1, 1, 0, 1, 1, 0));
        // Reset back to pointer 0, then move pointer to 2 via VC1
        tbl.push_back(mk(0, F, D, F, F, D, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0010, D, F, F, D, 1, 1, 1, 1, 1, 1, 0));
        // VC2 head, two bodies, bubble, tail; then VC0 after pointer -> 3
        tbl.push_back(mk(1, 4'b0111, D, Z, F, D, 1, 1, 1, 2, 1, 1, 0));
        tbl.push_back(mk(1, 4'b0111, D, Z, F, D, 1, 1, 1, 2, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0111, D, Z, F, D, 1, 1, 1, 2, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0011, D, Z, F, D, 1, 1, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0111, D, 4'b0100, F, D, 1, 1, 1, 2, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0111, D, F, F, D, 1, 1, 1, 0, 1, 1, 0));
        // Credit skip: pointer 1, VC1 without credit -> VC2
        tbl.push_back(mk(1, 4'b0110, D, F, 4'b1101, D, 1, 1, 1, 2, 1, 1, 0));
        // sel_valid low: grant visible, no dispatch, pointer stays at 3
        tbl.push_back(mk(1, F, D, F, F, D, 0, 1, 1, 3, 1, 0, 0));
        tbl.push_back(mk(1, F, D, F, F, D, 1, 1, 1, 3, 1, 1, 0));
        // Direction mismatch: nothing eligible
        tbl.push_back(mk(1, F, D, F, F, 4'b0100, 1, 1, 1, 0, 0, 0, 0));
        // Lock on VC2, direction changes away and back, lock survives
        tbl.push_back(mk(1, 4'b0100, D, Z, F, D, 1, 1, 1, 2, 1, 1, 0));
        tbl.push_back(mk(1, 4'b0100, D, Z, F, 4'b0100, 1, 1, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0100, D, 4'b0100, F, D, 1, 1, 1, 2, 1, 1, 1));
        tbl.push_back(mk(1, Z, D, F, F, D, 1, 1, 1, 0, 0, 0, 0));
        // Fixed priority: VCs 1 and 3 eligible -> 3, three cycles
        tbl.push_back(mk(1, 4'b1010, D, F, F, D, 1, 0, 1, 3, 1, 1, 0));
        tbl.push_back(mk(1, 4'b1010, D, F, F, D, 1, 0, 1, 3, 1, 1, 0));
        tbl.push_back(mk(1, 4'b1010, D, F, F, D, 1, 0, 1, 3, 1, 1, 0));
        // Fixed priority with VC3 out of credit -> 1
        tbl.push_back(mk(1, 4'b1010, D, F, 4'b0111, D, 1, 0, 1, 1, 1, 1, 0));
        // Fixed priority lock on VC1 ignores higher VC3 until tail
        tbl.push_back(mk(1, 4'b0011, D, Z, F, D, 1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 4'b1011, D, Z, F, D, 1, 0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(1, 4'b1011, D, 4'b0010, F, D, 1, 0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(1, 4'b1011, D, F, F, D, 1, 0, 1, 3, 1, 1, 0));

        reset = 1'b0; vc_valid = '0; vc_direction = '0; vc_tail = '0;
        vc_credit_ok = '0; sel_direction = '0; sel_valid = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Reset in the middle of a VC3 packet drops the lock and the pointer
        apply(mk(0, F, D, F, F, D, 1, 1, 0, 0, 0, 0, 0), 100);
        apply(mk(1, 4'b1000, D, Z, F, D, 1, 1, 1, 3, 1, 1, 0), 101);
        apply(mk(1, 4'b1000, D, Z, F, D, 1, 1, 1, 3, 1, 1, 1), 102);
        apply(mk(0, 4'b1000, D, Z, F, D, 1, 1, 0, 0, 0, 0, 0), 103);
        apply(mk(1, F, D, F, F, D, 1, 1, 1, 0, 1, 1, 0), 104);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
